// File: rtl/adder_accumulator.sv
// Frame accumulator for 3-bit adder results with valid/ready in and out ports.
// Optional build macro ADDER_ACC_SATURATE_EN: saturate instead of wrap on overflow.
module adder_accumulator #(
  parameter int ACC_W = 8,
  parameter int COUNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_sum,
  input  logic             in_carry,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_total,
  output logic             out_overflow
);

  localparam int CNT_W = $clog2(COUNT + 1);

  typedef enum logic {
    ACCUM,
    HOLD
  } state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] acc, acc_next;
  logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;
  logic             ovf, ovf_next;
  logic [ACC_W-1:0] total_next;
  logic             overflow_next;

  logic [ACC_W-1:0] v_ext;
  logic [ACC_W:0]   sum_wide;
  logic             carry;
  logic [ACC_W-1:0] add_result;

  assign v_ext    = ACC_W'({in_carry, in_sum});
  assign sum_wide = {1'b0, acc} + {1'b0, v_ext};
  assign carry    = sum_wide[ACC_W];
  assign cnt_inc  = cnt + CNT_W'(1);

  // Once saturated, acc stays at all ones: any nonzero add carries again.
`ifdef ADDER_ACC_SATURATE_EN
  assign add_result = carry ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
  assign add_result = sum_wide[ACC_W-1:0];
`endif

  always_comb begin
    state_next    = state;
    acc_next      = acc;
    cnt_next      = cnt;
    ovf_next      = ovf;
    total_next    = out_total;
    overflow_next = out_overflow;
    unique case (state)
      ACCUM: begin
        if (in_valid) begin
          acc_next = add_result;
          cnt_next = cnt_inc;
          ovf_next = ovf | carry;
          if (cnt_inc == CNT_W'(COUNT)) begin
            state_next    = HOLD;
            total_next    = add_result;
            overflow_next = ovf | carry;
          end
        end
      end
      HOLD: begin
        if (out_ready) begin
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
          state_next = ACCUM;
        end
      end
      default: state_next = ACCUM;
    endcase
  end

  // Handshake flags are registered copies of the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ACCUM;
      acc          <= '0;
      cnt          <= '0;
      ovf          <= 1'b0;
      out_total    <= '0;
      out_overflow <= 1'b0;
      in_ready     <= 1'b1;
      out_valid    <= 1'b0;
    end else begin
      state        <= state_next;
      acc          <= acc_next;
      cnt          <= cnt_next;
      ovf          <= ovf_next;
      out_total    <= total_next;
      out_overflow <= overflow_next;
      in_ready     <= (state_next == ACCUM);
      out_valid    <= (state_next == HOLD);
    end
  end

endmodule

// File: tb/tb_adder_accumulator.sv
// Directed self-checking bench for adder_accumulator: three instances cover
// the default (8-bit, 4 per frame), narrow 3-bit wrap/saturate, and COUNT=1.
module tb_adder_accumulator;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // Instance A: ACC_W=8, COUNT=4
  logic       a_in_valid = 1'b0, a_in_ready, a_in_carry = 1'b0;
  logic [1:0] a_in_sum = 2'd0;
  logic       a_out_valid, a_out_ready = 1'b0, a_out_overflow;
  logic [7:0] a_out_total;

  // Instance B: ACC_W=3, COUNT=4
  logic       b_in_valid = 1'b0, b_in_ready, b_in_carry = 1'b0;
  logic [1:0] b_in_sum = 2'd0;
  logic       b_out_valid, b_out_ready = 1'b0, b_out_overflow;
  logic [2:0] b_out_total;

  // Instance C: ACC_W=8, COUNT=1
  logic       c_in_valid = 1'b0, c_in_ready, c_in_carry = 1'b0;
  logic [1:0] c_in_sum = 2'd0;
  logic       c_out_valid, c_out_ready = 1'b0, c_out_overflow;
  logic [7:0] c_out_total;

  adder_accumulator #(.ACC_W(8), .COUNT(4)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_sum(a_in_sum), .in_carry(a_in_carry),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_total(a_out_total),
    .out_overflow(a_out_overflow)
  );

  adder_accumulator #(.ACC_W(3), .COUNT(4)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sum(b_in_sum), .in_carry(b_in_carry),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_total(b_out_total),
    .out_overflow(b_out_overflow)
  );

  adder_accumulator #(.ACC_W(8), .COUNT(1)) dut_c (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_sum(c_in_sum), .in_carry(c_in_carry),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_total(c_out_total),
    .out_overflow(c_out_overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_a(input logic vld, input logic [2:0] v);
    a_in_valid = vld;
    {a_in_carry, a_in_sum} = v;
  endtask

  task automatic drive_b(input logic vld, input logic [2:0] v);
    b_in_valid = vld;
    {b_in_carry, b_in_sum} = v;
  endtask

  task automatic drive_c(input logic vld, input logic [2:0] v);
    c_in_valid = vld;
    {c_in_carry, c_in_sum} = v;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_a(1'b1, 3'd5);
    drive_b(1'b1, 3'd7);
    drive_c(1'b1, 3'd6);
    tick();
    rst = 1'b0;
    drive_a(1'b0, 3'd0);
    drive_b(1'b0, 3'd0);
    drive_c(1'b0, 3'd0);
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_out_total !== 8'd0) begin errors++; $display("[TB] FAIL reset_out_total: got %0d expected 0", a_out_total); end
    checks++; if (a_out_overflow !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_overflow: got %b expected 0", a_out_overflow); end
    checks++; if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_b_handshake: got valid=%b ready=%b expected 0/1", b_out_valid, b_in_ready); end
    checks++; if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_c_handshake: got valid=%b ready=%b expected 0/1", c_out_valid, c_in_ready); end
  endtask

  task automatic test_basic_frame();
    logic [2:0] vals [4];
    vals = '{3'd5, 3'd7, 3'd2, 3'd4};
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, vals[i]);
      tick();
      if (i == 2) begin
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_early_valid: got %b expected 0", a_out_valid); end
      end
    end
    drive_a(1'b0, 3'd0);
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL basic_out_valid: got %b expected 1", a_out_valid); end
    checks++; if (a_out_total !== 8'd18) begin errors++; $display("[TB] FAIL basic_total: got %0d expected 18", a_out_total); end
    checks++; if (a_out_overflow !== 1'b0) begin errors++; $display("[TB] FAIL basic_overflow: got %b expected 0", a_out_overflow); end
    checks++; if (a_in_ready !== 1'b0) begin errors++; $display("[TB] FAIL basic_in_ready_hold: got %b expected 0", a_in_ready); end
    tick();
    checks++; if (a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL basic_in_ready_back: got %b expected 1", a_in_ready); end
    checks++; if (a_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_valid_cleared: got %b expected 0", a_out_valid); end
  endtask

  task automatic test_wrap_or_saturate();
    logic [2:0] exp_total;
`ifdef ADDER_ACC_SATURATE_EN
    exp_total = 3'd7;
`else
    exp_total = 3'd4;
`endif
    b_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, 3'd7);
      tick();
    end
    drive_b(1'b0, 3'd0);
    checks++; if (b_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL wrap_valid: got %b expected 1", b_out_valid); end
    checks++; if (b_out_total !== exp_total) begin errors++; $display("[TB] FAIL wrap_total: got %0d expected %0d", b_out_total, exp_total); end
    checks++; if (b_out_overflow !== 1'b1) begin errors++; $display("[TB] FAIL wrap_overflow: got %b expected 1", b_out_overflow); end
    tick();
    for (int i = 0; i < 4; i++) begin
      drive_b(1'b1, 3'd1);
      tick();
    end
    drive_b(1'b0, 3'd0);
    checks++; if (b_out_total !== 3'd4) begin errors++; $display("[TB] FAIL second_frame_total: got %0d expected 4", b_out_total); end
    checks++; if (b_out_overflow !== 1'b0) begin errors++; $display("[TB] FAIL second_frame_overflow: got %b expected 0", b_out_overflow); end
    tick();
  endtask

  task automatic test_backpressure();
    logic [2:0] vals [4];
    vals = '{3'd1, 3'd2, 3'd3, 3'd0};
    a_out_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      if (i % 2 == 0) drive_a(1'b1, vals[i / 2]);
      else            drive_a(1'b0, 3'd7);
      tick();
    end
    checks++; if (a_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid: got %b expected 1", a_out_valid); end
    checks++; if (a_out_total !== 8'd6) begin errors++; $display("[TB] FAIL bp_total: got %0d expected 6", a_out_total); end
    for (int i = 0; i < 5; i++) begin
      drive_a(i % 2 == 0, 3'd7);
      tick();
      checks++;
      if (a_out_valid !== 1'b1 || a_out_total !== 8'd6 || a_in_ready !== 1'b0 || a_out_overflow !== 1'b0) begin
        errors++;
        $display("[TB] FAIL bp_stall_%0d: got valid=%b total=%0d ready=%b ovf=%b expected 1/6/0/0",
                 i, a_out_valid, a_out_total, a_in_ready, a_out_overflow);
      end
    end
    drive_a(1'b0, 3'd0);
    a_out_ready = 1'b1;
    tick();
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL bp_release: got valid=%b ready=%b expected 0/1", a_out_valid, a_in_ready); end
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 3'd1);
      tick();
    end
    drive_a(1'b0, 3'd0);
    checks++; if (a_out_total !== 8'd4) begin errors++; $display("[TB] FAIL bp_next_frame_total: got %0d expected 4", a_out_total); end
    tick();
  endtask

  task automatic test_reset_mid_frame();
    a_out_ready = 1'b1;
    drive_a(1'b1, 3'd3);
    tick();
    tick();
    drive_a(1'b0, 3'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL midrst_handshake: got valid=%b ready=%b expected 0/1", a_out_valid, a_in_ready); end
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 3'd1);
      tick();
    end
    drive_a(1'b0, 3'd0);
    checks++; if (a_out_valid !== 1'b1 || a_out_total !== 8'd4) begin errors++; $display("[TB] FAIL midrst_total: got valid=%b total=%0d expected 1/4", a_out_valid, a_out_total); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL holdrst_handshake: got valid=%b ready=%b expected 0/1", a_out_valid, a_in_ready); end
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_a(1'b1, 3'd2);
      tick();
    end
    drive_a(1'b0, 3'd0);
    checks++; if (a_out_valid !== 1'b1 || a_out_total !== 8'd8) begin errors++; $display("[TB] FAIL holdrst_next_total: got valid=%b total=%0d expected 1/8", a_out_valid, a_out_total); end
    tick();
  endtask

  task automatic test_count_one();
    logic [2:0] vals [3];
    vals = '{3'd6, 3'd3, 3'd7};
    c_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_c(1'b1, vals[i]);
      checks++; if (c_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL c1_in_ready_%0d: got %b expected 1", i, c_in_ready); end
      tick();
      checks++;
      if (c_out_valid !== 1'b1 || c_out_total !== 8'(vals[i])) begin
        errors++;
        $display("[TB] FAIL c1_total_%0d: got valid=%b total=%0d expected 1/%0d", i, c_out_valid, c_out_total, vals[i]);
      end
      tick();
      checks++; if (c_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL c1_bubble_%0d: got %b expected 0", i, c_out_valid); end
    end
    drive_c(1'b0, 3'd0);
  endtask

  initial begin
    $display("[TB] adder_accumulator directed test start");
    tick();
    test_reset();
    test_basic_frame();
    test_wrap_or_saturate();
    test_backpressure();
    test_reset_mid_frame();
    test_count_one();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_accumulator.md
# adder_accumulator

Downstream consumer of the 2-bit adder stage. Each cycle it can accept one adder result, `{carry_out, sum}`, treated as an unsigned 3-bit value in the range 0..7. It sums a frame of `COUNT` consecutive results into an `ACC_W`-bit running total and presents the frame total on a valid/ready output port with a sticky overflow flag. Input and output both use valid/ready handshakes; all outputs are registered.

## Interface
Parameters:
- `ACC_W`, default 8: accumulator and output width. Legal values are ≥ 3.
- `COUNT`, default 4: adder results per frame. Legal values are ≥ 1. The internal sample counter is `$clog2(COUNT+1)` bits wide.

Ports (name, direction, width, meaning):
- `clk`, input, 1: the single clock; everything is on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `in_valid`, input, 1: upstream adder result is present.
- `in_ready`, output, 1: block accepts the result this cycle.
- `in_sum`, input, 2: `sum` from the adder.
- `in_carry`, input, 1: `carry_out` from the adder.
- `out_valid`, output, 1: frame total is available.
- `out_ready`, input, 1: downstream takes the total.
- `out_total`, output, `ACC_W`: frame total.
- `out_overflow`, output, 1: the frame total exceeded `2^ACC_W - 1`.

## Operation
- Input value: `v = {in_carry, in_sum}`, zero-extended to `ACC_W`.
- An input is accepted when `in_valid && in_ready`. An output is taken when `out_valid && out_ready`.
- The state machine has two states, `ACCUM` and `HOLD`. `ACCUM` is the reset state.

ACCUM state:
- `in_ready = 1` and `out_valid = 0`.
- On accept: `acc <= acc + v` and `cnt <= cnt + 1`.
- If the addition carries out of `ACC_W`, `ovf <= 1`. The flag is sticky within the frame.
- On the accept that makes the count equal `COUNT`, go to `HOLD`. In that same edge:
  - the final sum is loaded into `out_total`;
  - `out_overflow` gets the updated `ovf`;
  - `out_valid` is set to 1.
- Cycles with `in_valid = 0` leave all state unchanged.

HOLD state:
- `in_ready = 0`. `in_valid`, `in_sum` and `in_carry` are ignored.
- `out_valid`, `out_total` and `out_overflow` hold stable until the output is taken.
- On take: `acc`, `cnt` and `ovf` clear to 0, `out_valid` clears to 0, and the state returns to `ACCUM`.
- `out_total` and `out_overflow` keep their last values after the take. They are meaningful only while `out_valid = 1`.

Arithmetic:
- The adder is unsigned with width `ACC_W + 1`. The MSB of that sum is the carry-out.
- Default behaviour is wrap: keep the low `ACC_W` bits.

## Timing
Reset values (cycle after `rst` is sampled high):
- `in_ready = 1`, `out_valid = 0`, `out_total = 0`, `out_overflow = 0`.
- State `ACCUM`, `acc = 0`, `cnt = 0`, `ovf = 0`.
- Reset has priority over every handshake.
- A reset in the middle of a frame discards the partial sum. A reset during `HOLD` drops the pending result without it being taken.

Latency and throughput:
- `out_valid` rises on the clock edge that accepts the last sample of a frame. It is visible in the following cycle.
- After a take, `in_ready` returns in the next cycle. There is no same-cycle bypass, so each frame costs exactly one bubble cycle.
- With continuous valid and ready, throughput is `COUNT` samples per `COUNT + 1` cycles.

`COUNT = 1`: every accepted sample goes straight to `HOLD`, and `out_total = v`.

Backpressure: `out_ready` low for any number of cycles stalls the block indefinitely, and the outputs do not change.

## Configuration
Macro `ADDER_ACC_SATURATE_EN`:
- Defined: on carry-out, `acc` saturates to all ones (`2^ACC_W - 1`) and stays there for the rest of the frame. `ovf` is still set. `out_total` never wraps.
- Undefined (default): modulo-`2^ACC_W` wrap. `ovf` is set on the first wrap.
- The handshake and timing are identical in both builds.

## Test plan
1. Basic frame (`ACC_W=8`, `COUNT=4`):
   - Stimulus: inputs 5, 7, 2, 4 on consecutive cycles, `out_ready = 1`.
   - Required response: `out_valid` high in the cycle after the 4th accept, `out_total = 18`, `out_overflow = 0`, `in_ready` low in that cycle and high again in the next.
2. Wrap (`ACC_W=3`, `COUNT=4`, macro undefined):
   - Stimulus: four inputs of 7.
   - Required response: `out_total = 4` (28 mod 8), `out_overflow = 1`.
3. Saturate (`ACC_W=3`, `COUNT=4`, macro defined):
   - Stimulus: four inputs of 7.
   - Required response: `out_total = 7`, `out_overflow = 1`.
   - Then a second frame of inputs 1, 1, 1, 1 gives `out_total = 4`, `out_overflow = 0`, which proves the flag cleared.
4. Bubbles and backpressure:
   - Stimulus: `in_valid` toggling 1, 0, 1, 0, … with values 1, 2, 3, 0; `out_ready` held low for 5 cycles after `out_valid` rises.
   - Required response:
     - `out_total = 6`, stable through the stall;
     - `in_ready = 0` throughout the stall;
     - extra `in_valid` pulses during the stall do not change the later frame sum.
5. Reset mid-frame:
   - Stimulus: accept 3 and 3, assert `rst` for one cycle, then send 1, 1, 1, 1.
   - Required response: `out_valid = 0` right after reset, then `out_total = 4`.
   - A second variant asserts `rst` during `HOLD`. Required response: `out_valid` drops to 0 and `in_ready` is 1 in the next cycle.
6. `COUNT = 1`, continuous streaming with `out_ready = 1`:
   - Stimulus: inputs 6, 3, 7.
   - Required response: totals 6, 3 and 7, each one output per 2 cycles.
